col_out_drain: RTL

//   Output-side counterpart of the array controller: collects skewed per-column results leaving
//   the systolic array, deskews them in per-column FIFOs, and serializes complete rows to the

---
 rtl/col_out_drain_pkg.sv | 22 ++
 rtl/col_out_drain_out_fifo.sv | 76 +++++++
 rtl/col_out_drain.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/col_out_drain_pkg.sv
// Shared definitions for the systolic-array output drain: default geometry,
// drain FSM encodings and the backpressure threshold helper.
package col_out_drain_pkg;

    localparam int COLS_DEF    = 16;
    localparam int WORDLEN_DEF = 8;
    localparam int DEPTH_DEF   = 8;
    localparam int CNTW_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } drain_state_e;

    // Fill level at which the array is held off; two slots of slack absorb the
    // in-flight push that lands in the cycle the registered stall rises.
    function automatic int unsigned stall_level(input int unsigned depth);
        return depth - 32'd2;
    endfunction

endpackage

// File: rtl/col_out_drain_out_fifo.sv
// Single-clock per-column deskew FIFO with flush; also exposes the post-update
// occupancy so the top can register backpressure without a cycle of lag.
module out_fifo #(
    parameter int WORDLEN = 8,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WORDLEN-1:0]       i_data,
    output logic [WORDLEN-1:0]       o_head,
    output logic [$clog2(DEPTH):0]   o_count_nxt,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORDLEN-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               w_push;
    logic               w_pop;
    logic [CW-1:0]      w_count_nxt;

    // Qualify push/pop against occupancy and compute the next count.
    always_comb begin
        o_full      = (r_count == CW'(DEPTH));
        o_empty     = (r_count == {CW{1'b0}});
        w_pop       = i_pop && !o_empty;
        w_push      = i_push && (!o_full || w_pop);
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = {CW{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_count_nxt = w_count_nxt;

    // Storage and pointer update; a flush discards everything including a same-cycle push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WORDLEN{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/col_out_drain.sv
// Output drain: deskews per-column array results in FIFOs and streams complete
// rows to the host one word per column, counting rows against the job total.
module col_out_drain
    import col_out_drain_pkg::*;
#(
    parameter int COLS    = COLS_DEF,
    parameter int WORDLEN = WORDLEN_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int CNTW    = CNTW_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [CNTW-1:0]         cfg_total,
    input  logic [COLS-1:0]         col_valid,
    input  logic [COLS*WORDLEN-1:0] col_data,
    output logic                    stall,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDLEN-1:0]      out_data,
    output logic                    out_last,
    output logic                    done,
    output logic                    overflow
);
    localparam int IW = $clog2(COLS);
    localparam int CW = $clog2(DEPTH) + 1;

    drain_state_e       r_state;
    logic [IW-1:0]      r_col_idx;
    logic [CNTW-1:0]    r_rows_out;
    logic [CNTW-1:0]    r_total;
    logic               r_done;
    logic               r_overflow;
    logic               r_stall;

    logic [COLS-1:0]    w_push;
    logic [COLS-1:0]    w_full;
    logic [COLS-1:0]    w_empty;
    logic [WORDLEN-1:0] w_head      [COLS];
    logic [CW-1:0]      w_count_nxt [COLS];
    logic               w_row_avail;
    logic               w_valid;
    logic               w_last_col;
    logic               w_accept;
    logic               w_pop_all;
    logic               w_ovf_evt;
    logic               w_stall_nxt;

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        out_fifo #(
            .WORDLEN (WORDLEN),
            .DEPTH   (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rstn        (rstn),
            .i_push      (w_push[c]),
            .i_pop       (w_pop_all),
            .i_flush     (start),
            .i_data      (col_data[c*WORDLEN +: WORDLEN]),
            .o_head      (w_head[c]),
            .o_count_nxt (w_count_nxt[c]),
            .o_full      (w_full[c]),
            .o_empty     (w_empty[c])
        );
    end

    // Row availability and handshake; start pre-empts any accept in its cycle.
    always_comb begin
        w_row_avail = &(~w_empty);
        w_valid     = (r_state == ST_RUN) && w_row_avail;
        w_last_col  = (r_col_idx == IW'(COLS - 1));
        w_accept    = w_valid && out_ready && !start;
        w_pop_all   = w_accept && w_last_col;
    end

    // Per-lane push qualification and overflow detection.
    always_comb begin
        w_push    = {COLS{1'b0}};
        w_ovf_evt = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (start || !col_valid[c]) begin
                w_push[c] = 1'b0;
            end else if (r_state == ST_RUN) begin
                if (w_full[c] && !w_pop_all) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_push[c] = 1'b1;
                end
            end else if (r_state == ST_DONE) begin
                w_ovf_evt = 1'b1;
            end else begin
                w_push[c] = 1'b0;
            end
        end
    end

    // Backpressure from post-update occupancy of every lane.
    always_comb begin
        w_stall_nxt = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (w_count_nxt[c] >= CW'(stall_level(DEPTH))) begin
                w_stall_nxt = 1'b1;
            end else begin
                w_stall_nxt = w_stall_nxt;
            end
        end
    end

    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_head[r_col_idx] : {WORDLEN{1'b0}};
    assign out_last  = w_valid && w_last_col;
    assign stall     = r_stall;
    assign done      = r_done;
    assign overflow  = r_overflow;

    // Drain FSM, column pointer, row counter and sticky status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_col_idx  <= {IW{1'b0}};
            r_rows_out <= {CNTW{1'b0}};
            r_total    <= {CNTW{1'b0}};
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_stall    <= 1'b0;
        end else if (start) begin
            r_state    <= (cfg_total == {CNTW{1'b0}}) ? ST_DONE : ST_RUN;
            r_col_idx  <= {IW{1'b0}};
            r_rows_out <= {CNTW{1'b0}};
            r_total    <= cfg_total;
            r_done     <= (cfg_total == {CNTW{1'b0}});
            r_overflow <= 1'b0;
            r_stall    <= w_stall_nxt;
        end else begin
            r_stall <= w_stall_nxt;
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_last_col) begin
                            r_col_idx  <= {IW{1'b0}};
                            r_rows_out <= r_rows_out + CNTW'(1);
                            if ((r_rows_out + CNTW'(1)) == r_total) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_col_idx <= r_col_idx + IW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
